// File: rtl/antiglitch_sched.sv
// Round-robin integrating glitch filter with a clean-level change event queue.
// Optional rejected-sample statistics counter: define ANTIGLITCH_SCHED_STAT_EN.

module antiglitch_chan #(
  parameter int LIM = 7,
  parameter int CW  = 3
) (
  input  logic clk,
  input  logic resetn,
  input  logic raw,
  input  logic svc,
  output logic clean,
  output logic chg
`ifdef ANTIGLITCH_SCHED_STAT_EN
  , output logic rej
`endif
);
  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          clean_nxt;

  assign s = sync[1];

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) sync <= '0;
    else         sync <= {sync[0], raw};

  always_comb begin
    cnt_nxt = cnt;
    if (s) begin
      if (cnt != CW'(LIM)) cnt_nxt = cnt + 1'b1;
    end else if (cnt != '0) begin
      cnt_nxt = cnt - 1'b1;
    end
    // hysteresis: level only moves at the integrator rails
    clean_nxt = clean;
    if (cnt_nxt == CW'(LIM))  clean_nxt = 1'b1;
    else if (cnt_nxt == '0)   clean_nxt = 1'b0;
  end

  assign chg = svc && (clean_nxt != clean);
`ifdef ANTIGLITCH_SCHED_STAT_EN
  assign rej = svc && (s != clean) && !chg;
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (svc) begin
      cnt   <= cnt_nxt;
      clean <= clean_nxt;
    end
endmodule

module antiglitch_sched #(
  parameter int NCH = 4,
  parameter int LIM = 7,
  parameter int QD  = 4
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   en,
  input  logic [NCH-1:0]         glitch,
  output logic [NCH-1:0]         clean,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [$clog2(NCH)-1:0] ev_ch,
  output logic                   ev_lvl,
  output logic                   ev_ovf,
  input  logic                   ovf_clr,
  output logic [15:0]            rej_cnt
);
  localparam int CW  = $clog2(LIM + 1);
  localparam int CHW = $clog2(NCH);
  localparam int AW  = $clog2(QD);

  typedef struct packed {
    logic [CHW-1:0] ch;
    logic           lvl;
  } ev_t;

  logic [CHW-1:0] ptr;
  logic [NCH-1:0] svc, chg;
`ifdef ANTIGLITCH_SCHED_STAT_EN
  logic [NCH-1:0] rej;
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn)  ptr <= '0;
    else if (en)  ptr <= (ptr == CHW'(NCH - 1)) ? '0 : ptr + 1'b1;

  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign svc[k] = en && (ptr == CHW'(k));
    antiglitch_chan #(.LIM(LIM), .CW(CW)) u_ch (
      .clk    (clk),
      .resetn (resetn),
      .raw    (glitch[k]),
      .svc    (svc[k]),
      .clean  (clean[k]),
      .chg    (chg[k])
`ifdef ANTIGLITCH_SCHED_STAT_EN
      , .rej  (rej[k])
`endif
    );
  end

  // only the serviced channel can change, so the event is always {ptr, ~old level}
  logic push, pop, wr, drop, full, empty;
  ev_t  ev_in;
  ev_t  q [QD];
  logic [AW:0] wp, rp;

  assign push     = |chg;
  assign ev_in    = '{ch: ptr, lvl: ~clean[ptr]};
  assign empty    = (wp == rp);
  assign full     = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign ev_valid = !empty;
  assign pop      = ev_valid && ev_ready;
  assign wr       = push && (!full || pop);
  assign drop     = push && full && !pop;
  assign ev_ch    = q[rp[AW-1:0]].ch;
  assign ev_lvl   = q[rp[AW-1:0]].lvl;

  always_ff @(posedge clk)
    if (wr) q[wp[AW-1:0]] <= ev_in;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wp     <= '0;
      rp     <= '0;
      ev_ovf <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (drop)         ev_ovf <= 1'b1;
      else if (ovf_clr) ev_ovf <= 1'b0;
    end

`ifdef ANTIGLITCH_SCHED_STAT_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rej_cnt <= '0;
    else if (|rej && rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 1'b1;
`else
  assign rej_cnt = '0;
`endif
endmodule

// File: tb/tb_antiglitch_sched.sv
// Directed bench for antiglitch_sched at default parameters (NCH=4, LIM=7, QD=4).
// Edges after reset release are numbered E1, E2, ...; E1 services channel 0.

module tb_antiglitch_sched;
`ifdef ANTIGLITCH_SCHED_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetn, en, ev_ready, ovf_clr;
  logic [3:0]  glitch, clean;
  logic        ev_valid, ev_lvl, ev_ovf;
  logic [1:0]  ev_ch;
  logic [15:0] rej_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  antiglitch_sched dut (
    .clk(clk), .resetn(resetn), .en(en), .glitch(glitch), .clean(clean),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ch(ev_ch), .ev_lvl(ev_lvl),
    .ev_ovf(ev_ovf), .ovf_clr(ovf_clr), .rej_cnt(rej_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rst_go(input logic [3:0] g);
    @(negedge clk);
    resetn = 1'b0; glitch = g; en = 1'b1; ev_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // all channels rise together, aligned so ch0..ch3 reach LIM at E29..E32
  task automatic fill;
    rst_go(4'h0);
    step(2);
    glitch = 4'hf;
    step(26);
    chk("fill_e28_valid", ev_valid, 0);
    step(1);
    chk("fill_e29_clean", clean, 4'h1);
    chk("fill_e29_valid", ev_valid, 1);
    step(3);
    chk("fill_e32_clean", clean, 4'hf);
    chk("fill_e32_ovf", ev_ovf, 0);
    chk("fill_e32_head", {ev_ch, ev_lvl}, {2'd0, 1'b1});
  endtask

  initial begin
    resetn = 1'b0; en = 1'b0; glitch = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    step(3);
    chk("rst_clean", clean, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_ovf", ev_ovf, 0);
    chk("rst_rej", rej_cnt, 0);

    // ch0 held high: rises at its 7th effective service
    rst_go(4'h1);
    step(28);
    chk("t1_e28_clean", clean, 0);
    step(1);
    chk("t1_e29_clean", clean, 4'h1);
    chk("t1_e29_head", {ev_valid, ev_ch, ev_lvl}, {1'b1, 2'd0, 1'b1});
    chk("t1_rej", rej_cnt, STAT ? 6 : 0);
    step(8);
    chk("t1_stable", clean, 4'h1);
    ev_ready = 1'b1; step(1); ev_ready = 1'b0;
    chk("t1_popped", ev_valid, 0);

    // short pulse on ch1 spans exactly two services
    rst_go(4'h0);
    step(5);
    glitch = 4'h2; step(8);
    glitch = 4'h0; step(12);
    chk("t2_clean", clean, 0);
    chk("t2_valid", ev_valid, 0);
    chk("t2_rej", rej_cnt, STAT ? 2 : 0);

    // full queue, ch0 falls at E61 with no pop: dropped even with ovf_clr
    fill();
    glitch = 4'he;
    step(28);
    chk("t3_e60_clean", clean, 4'hf);
    chk("t3_e60_ovf", ev_ovf, 0);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    chk("t3_e61_clean", clean, 4'he);
    chk("t3_drop_wins", ev_ovf, 1);
    step(1);
    chk("t3_ovf_held", ev_ovf, 1);
    ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
    chk("t3_ovf_clr", ev_ovf, 0);
    for (int k = 0; k < 4; k++) begin
      chk("t3_q", {ev_valid, ev_ch, ev_lvl}, {1'b1, 2'(k), 1'b1});
      ev_ready = 1'b1; step(1); ev_ready = 1'b0;
    end
    chk("t3_empty", ev_valid, 0);

    // full queue, pop coincides with the E61 push: both succeed
    fill();
    glitch = 4'he;
    step(28);
    ev_ready = 1'b1; step(1); ev_ready = 1'b0;
    chk("t4_ovf", ev_ovf, 0);
    chk("t4_clean", clean, 4'he);
    for (int k = 0; k < 4; k++) begin
      chk("t4_q", {ev_valid, ev_ch, ev_lvl}, {1'b1, 2'((k + 1) % 4), k < 3});
      ev_ready = 1'b1; step(1); ev_ready = 1'b0;
    end
    chk("t4_empty", ev_valid, 0);

    // freeze with ch2 counter at 3 and ptr at 1; resume must service ch1 first
    rst_go(4'h0);
    step(2);
    glitch = 4'h4;
    step(15);
    en = 1'b0;
    step(21);
    chk("t5_frozen_clean", clean, 0);
    chk("t5_frozen_valid", ev_valid, 0);
    en = 1'b1;
    step(13);
    chk("t5_f13_clean", clean, 0);
    step(1);
    chk("t5_f14_clean", clean, 4'h4);
    chk("t5_head", {ev_valid, ev_ch, ev_lvl}, {1'b1, 2'd2, 1'b1});

    // asynchronous reset with three events queued
    fill();
    ev_ready = 1'b1; step(1); ev_ready = 1'b0;
    chk("t6_head", ev_ch, 1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_clean", clean, 0);
    chk("t6_valid", ev_valid, 0);
    chk("t6_ovf", ev_ovf, 0);
    chk("t6_rej", rej_cnt, 0);
    glitch = 4'h0;
    @(negedge clk);
    resetn = 1'b1;
    step(40);
    chk("t6_post_valid", ev_valid, 0);
    chk("t6_post_clean", clean, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
